// File: rtl/mem_arbiter_pkg.sv
// Shared layer-controller memory definitions: bus widths, arbiter state
// encodings and the memory command record latched on each grant.
package mem_arbiter_pkg;

    localparam int LC_MEM_ADDR_WIDTH = 30;
    localparam int LC_MEM_DATA_WIDTH = 32;

    typedef logic [LC_MEM_ADDR_WIDTH-1:0] lc_addr_t;
    typedef logic [LC_MEM_DATA_WIDTH-1:0] lc_data_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic     write;
        lc_addr_t addr;
        lc_data_t din;
    } mem_cmd_t;

    // Selects the command of the winning port (0 or 1).
    function automatic mem_cmd_t pick_cmd(input logic sel, input mem_cmd_t c0, input mem_cmd_t c1);
        return sel ? c1 : c0;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester handshakes and the shared memory handshake.
// The arbiter uses the slave view; requesters and memory sit on the master view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic     REQ0;
    logic     REQ1;
    logic     WRITE0;
    logic     WRITE1;
    lc_addr_t ADDR0;
    lc_addr_t ADDR1;
    lc_data_t DIN0;
    lc_data_t DIN1;
    logic     ACK0;
    logic     ACK1;
    lc_data_t DOUT0;
    lc_data_t DOUT1;
    logic     ERR0;
    logic     ERR1;

    logic     MEM_REQ;
    logic     MEM_WRITE;
    lc_addr_t MEM_ADDR;
    lc_data_t MEM_DIN;
    lc_data_t MEM_DOUT;
    logic     MEM_ACK_IN;

    modport slave (
        input  REQ0, REQ1, WRITE0, WRITE1, ADDR0, ADDR1, DIN0, DIN1,
        output ACK0, ACK1, DOUT0, DOUT1, ERR0, ERR1,
        output MEM_REQ, MEM_WRITE, MEM_ADDR, MEM_DIN,
        input  MEM_DOUT, MEM_ACK_IN
    );

    modport master (
        output REQ0, REQ1, WRITE0, WRITE1, ADDR0, ADDR1, DIN0, DIN1,
        input  ACK0, ACK1, DOUT0, DOUT1, ERR0, ERR1,
        input  MEM_REQ, MEM_WRITE, MEM_ADDR, MEM_DIN,
        output MEM_DOUT, MEM_ACK_IN
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin winner select. With both inputs requesting, the
// port that was not served last wins; otherwise the lone requester wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    // Combinational winner pick from the request pair and last-served port.
    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the layer-controller memory port.
// Each grant latches the winner's command, waits for the memory ACK (bounded
// by ACK_TIMEOUT) and completes the requester's four-phase handshake.
//
// state | meaning
// IDLE  | no grant; pick a winner from REQ0/REQ1 and launch MEM_REQ
// ISSUE | MEM_REQ high, waiting for MEM_ACK_IN or timeout
// RESP  | ACK (and ERR) high on granted port, waiting for its REQ to fall
// DRAIN | waiting for MEM_ACK_IN low, absorbs a late ACK after a timeout
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_WIDTH    = 8
) (
    input logic          CLK,
    input logic          RESETn,
    mem_arbiter_if.slave bus
);

    // Counter value on the last cycle allowed in ISSUE.
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(ACK_TIMEOUT - 1);

    arb_state_e          state_q, state_d;
    logic [TO_WIDTH-1:0] cnt_q, cnt_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic                mem_req_q, mem_req_d;
    mem_cmd_t            cmd_q, cmd_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;
    lc_data_t            dout0_q, dout0_d;
    lc_data_t            dout1_q, dout1_d;

    logic                arb_valid;
    logic                arb_winner;
    logic                req_gnt;
    mem_cmd_t            cmd_p0;
    mem_cmd_t            cmd_p1;

    rr_arb2 u_rr_arb2 (
        .req0   (bus.REQ0),
        .req1   (bus.REQ1),
        .last   (last_q),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    assign cmd_p0  = {bus.WRITE0, bus.ADDR0, bus.DIN0};
    assign cmd_p1  = {bus.WRITE1, bus.ADDR1, bus.DIN1};
    assign req_gnt = gnt_q ? bus.REQ1 : bus.REQ0;

    assign bus.MEM_REQ   = mem_req_q;
    assign bus.MEM_WRITE = cmd_q.write;
    assign bus.MEM_ADDR  = cmd_q.addr;
    assign bus.MEM_DIN   = cmd_q.din;
    assign bus.ACK0      = ack0_q;
    assign bus.ACK1      = ack1_q;
    assign bus.ERR0      = err0_q;
    assign bus.ERR1      = err1_q;
    assign bus.DOUT0     = dout0_q;
    assign bus.DOUT1     = dout1_q;

    // Next-state, timeout counter and per-port response updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        mem_req_d = mem_req_q;
        cmd_d     = cmd_q;
        ack0_d    = ack0_q;
        ack1_d    = ack1_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        dout0_d   = dout0_q;
        dout1_d   = dout1_q;

        case (state_q)
            ARB_IDLE: begin
                if (arb_valid) begin
                    gnt_d     = arb_winner;
                    cmd_d     = pick_cmd(arb_winner, cmd_p0, cmd_p1);
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ARB_ISSUE;
                end
            end

            ARB_ISSUE: begin
                if (bus.MEM_ACK_IN) begin
                    mem_req_d = 1'b0;
                    state_d   = ARB_RESP;
                    if (gnt_q) begin
                        ack1_d = 1'b1;
                        err1_d = 1'b0;
                        if (!cmd_q.write) begin
                            dout1_d = bus.MEM_DOUT;
                        end
                    end else begin
                        ack0_d = 1'b1;
                        err0_d = 1'b0;
                        if (!cmd_q.write) begin
                            dout0_d = bus.MEM_DOUT;
                        end
                    end
                end else if (cnt_q == TO_LAST) begin
                    // Memory never answered; report the error and let DRAIN
                    // soak up any acknowledge that shows up afterwards.
                    mem_req_d = 1'b0;
                    state_d   = ARB_RESP;
                    if (gnt_q) begin
                        ack1_d = 1'b1;
                        err1_d = 1'b1;
                    end else begin
                        ack0_d = 1'b1;
                        err0_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ARB_RESP: begin
                if (!req_gnt) begin
                    if (gnt_q) begin
                        ack1_d = 1'b0;
                        err1_d = 1'b0;
                    end else begin
                        ack0_d = 1'b0;
                        err0_d = 1'b0;
                    end
                    last_d  = gnt_q;
                    state_d = ARB_DRAIN;
                end
            end

            ARB_DRAIN: begin
                if (!bus.MEM_ACK_IN) begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, command and response registers; reset leaves port 0 first in line.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            mem_req_q <= 1'b0;
            cmd_q     <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            dout0_q   <= '0;
            dout1_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            mem_req_q <= mem_req_d;
            cmd_q     <= cmd_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small four-phase memory model.
// Model latency N means MEM_ACK_IN is first sampled high N edges after
// MEM_REQ rose, so the port ACK is expected N cycles after MEM_REQ.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .ACK_TIMEOUT (4),
        .TO_WIDTH    (3)
    ) dut (
        .CLK    (clk),
        .RESETn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model
    lc_data_t mem [0:63];
    logic     mem_en;
    int       mem_lat;
    int       lat_cnt;
    logic     model_ack;
    logic     man_ack;
    lc_data_t model_dout;

    assign bus.MEM_ACK_IN = model_ack | man_ack;
    assign bus.MEM_DOUT   = model_dout;

    always @(negedge clk) begin
        if (!bus.MEM_REQ) begin
            model_ack <= 1'b0;
            lat_cnt   <= 0;
        end else if (mem_en && !model_ack && !man_ack) begin
            lat_cnt <= lat_cnt + 1;
            if (lat_cnt + 1 >= mem_lat) begin
                model_ack <= 1'b1;
                if (bus.MEM_WRITE) mem[bus.MEM_ADDR[5:0]] <= bus.MEM_DIN;
                else               model_dout <= mem[bus.MEM_ADDR[5:0]];
            end
        end
    end

    // Requester protocol monitor: REQ must not fall before its ACK.
    logic prev_req0, prev_req1;
    int   viol = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_req0 <= 1'b0;
            prev_req1 <= 1'b0;
        end else begin
            prev_req0 <= bus.REQ0;
            prev_req1 <= bus.REQ1;
            if ((prev_req0 && !bus.REQ0 && !bus.ACK0) || (prev_req1 && !bus.REQ1 && !bus.ACK1))
                viol <= viol + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_mem_req(input int max, output bit to);
        to = 1'b1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.MEM_REQ) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_any_ack(input int max, output int n, output bit to);
        n  = 0;
        to = 1'b1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            n++;
            if (bus.ACK0 || bus.ACK1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1} !== 4'b0) begin n_bad++; $display("FAIL reset_ack_err: got %b want 0000", {bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1}); end
        n_cmp++; if ({bus.MEM_REQ, bus.MEM_WRITE} !== 2'b0) begin n_bad++; $display("FAIL reset_mem_req_write: got %b want 00", {bus.MEM_REQ, bus.MEM_WRITE}); end
        n_cmp++; if ({bus.MEM_ADDR, bus.MEM_DIN} !== '0) begin n_bad++; $display("FAIL reset_mem_addr_din: got %h/%h want 0/0", bus.MEM_ADDR, bus.MEM_DIN); end
        n_cmp++; if ({bus.DOUT0, bus.DOUT1} !== '0) begin n_bad++; $display("FAIL reset_dout: got %h/%h want 0/0", bus.DOUT0, bus.DOUT1); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        bit to;
        int n;
        int ack1_seen;
        ack1_seen = 0;
        mem_lat = 2;
        bus.REQ0 = 1'b1; bus.WRITE0 = 1'b0; bus.ADDR0 = 30'h10;
        wait_mem_req(10, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rd_mem_req_timeout: got timeout want MEM_REQ"); end
        n_cmp++; if ({bus.MEM_WRITE, bus.MEM_ADDR} !== {1'b0, 30'h10}) begin n_bad++; $display("FAIL rd_mem_cmd: got w=%b a=%h want w=0 a=10", bus.MEM_WRITE, bus.MEM_ADDR); end
        wait_any_ack(10, n, to);
        if (bus.ACK1) ack1_seen++;
        n_cmp++; if ({to, bus.ACK0} !== 2'b01) begin n_bad++; $display("FAIL rd_ack0: got to=%b ack0=%b want 0/1", to, bus.ACK0); end
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d want 2", n); end
        n_cmp++; if (bus.DOUT0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_dout0: got %h want deadbeef", bus.DOUT0); end
        n_cmp++; if (bus.ERR0 !== 1'b0) begin n_bad++; $display("FAIL rd_err0: got %b want 0", bus.ERR0); end
        bus.REQ0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.ACK1) ack1_seen++;
        end
        n_cmp++; if (bus.ACK0 !== 1'b0) begin n_bad++; $display("FAIL rd_ack0_fall: got %b want 0", bus.ACK0); end
        n_cmp++; if (ack1_seen !== 0) begin n_bad++; $display("FAIL rd_ack1_quiet: got %0d want 0", ack1_seen); end
    endtask

    task automatic test_contention();
        bit       to;
        int       n;
        int       got;
        lc_data_t exp_d;
        do_reset();
        mem_lat = 2;
        bus.WRITE0 = 1'b0; bus.ADDR0 = 30'h1;
        bus.WRITE1 = 1'b0; bus.ADDR1 = 30'h2;
        bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_any_ack(20, n, to);
            n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL cont_ack_timeout: grant %0d got timeout want ack", g); break; end
            got = bus.ACK1 ? 1 : 0;
            n_cmp++; if (got !== g % 2) begin n_bad++; $display("FAIL cont_order: grant %0d got port %0d want %0d", g, got, g % 2); end
            n_cmp++; if ((bus.ACK0 && bus.ACK1) !== 1'b0) begin n_bad++; $display("FAIL cont_both_ack: got 1 want 0"); end
            exp_d = (g % 2) ? 32'h22222222 : 32'h11111111;
            n_cmp++; if ((got ? bus.DOUT1 : bus.DOUT0) !== exp_d) begin n_bad++; $display("FAIL cont_dout: grant %0d got %h want %h", g, got ? bus.DOUT1 : bus.DOUT0, exp_d); end
            if (got == 1) bus.REQ1 = 1'b0; else bus.REQ0 = 1'b0;
            @(negedge clk);
            if (g < 2) begin
                if (got == 1) bus.REQ1 = 1'b1; else bus.REQ0 = 1'b1;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_readback();
        bit to;
        int n;
        bus.REQ1 = 1'b1; bus.WRITE1 = 1'b1; bus.ADDR1 = 30'h20; bus.DIN1 = 32'h5A5A5A5A;
        wait_mem_req(10, to);
        n_cmp++; if ({to, bus.MEM_WRITE, bus.MEM_ADDR, bus.MEM_DIN} !== {1'b0, 1'b1, 30'h20, 32'h5A5A5A5A}) begin n_bad++; $display("FAIL wr_mem_cmd: got to=%b w=%b a=%h d=%h want 0/1/20/5a5a5a5a", to, bus.MEM_WRITE, bus.MEM_ADDR, bus.MEM_DIN); end
        wait_any_ack(10, n, to);
        n_cmp++; if ({to, bus.ACK1, bus.ERR1} !== 3'b010) begin n_bad++; $display("FAIL wr_ack1: got to=%b ack=%b err=%b want 0/1/0", to, bus.ACK1, bus.ERR1); end
        n_cmp++; if (bus.DOUT1 !== 32'h22222222) begin n_bad++; $display("FAIL wr_dout1_held: got %h want 22222222", bus.DOUT1); end
        bus.REQ1 = 1'b0; bus.WRITE1 = 1'b0;
        @(negedge clk);
        bus.REQ0 = 1'b1; bus.WRITE0 = 1'b0; bus.ADDR0 = 30'h20;
        wait_mem_req(10, to);
        n_cmp++; if ({to, bus.MEM_WRITE, bus.MEM_ADDR} !== {1'b0, 1'b0, 30'h20}) begin n_bad++; $display("FAIL rb_mem_cmd: got to=%b w=%b a=%h want 0/0/20", to, bus.MEM_WRITE, bus.MEM_ADDR); end
        wait_any_ack(10, n, to);
        n_cmp++; if ({to, bus.ACK0, bus.DOUT0} !== {1'b0, 1'b1, 32'h5A5A5A5A}) begin n_bad++; $display("FAIL rb_dout0: got to=%b ack=%b d=%h want 0/1/5a5a5a5a", to, bus.ACK0, bus.DOUT0); end
        bus.REQ0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit to;
        int n;
        int req_seen;
        mem_en = 1'b0;
        bus.REQ1 = 1'b1; bus.WRITE1 = 1'b0; bus.ADDR1 = 30'h3;
        wait_mem_req(10, to);
        wait_any_ack(10, n, to);
        n_cmp++; if ({to, bus.ACK1, bus.ERR1} !== 3'b011) begin n_bad++; $display("FAIL to_ack_err1: got to=%b ack=%b err=%b want 0/1/1", to, bus.ACK1, bus.ERR1); end
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL to_cycles: got %0d want 4", n); end
        n_cmp++; if ({bus.MEM_REQ, bus.DOUT1} !== {1'b0, 32'h22222222}) begin n_bad++; $display("FAIL to_memreq_dout1: got %b/%h want 0/22222222", bus.MEM_REQ, bus.DOUT1); end
        man_ack = 1'b1;
        bus.REQ1 = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.ACK1, bus.ERR1} !== 2'b00) begin n_bad++; $display("FAIL to_ack_err_fall: got %b%b want 00", bus.ACK1, bus.ERR1); end
        mem_en = 1'b1;
        bus.REQ0 = 1'b1; bus.WRITE0 = 1'b0; bus.ADDR0 = 30'h10;
        req_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.MEM_REQ) req_seen++;
        end
        n_cmp++; if (req_seen !== 0) begin n_bad++; $display("FAIL to_drain_hold: got %0d MEM_REQ cycles want 0", req_seen); end
        man_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.MEM_REQ !== 1'b0) begin n_bad++; $display("FAIL to_gap_idle: got %b want 0", bus.MEM_REQ); end
        @(negedge clk);
        n_cmp++; if (bus.MEM_REQ !== 1'b1) begin n_bad++; $display("FAIL to_next_grant: got %b want 1", bus.MEM_REQ); end
        wait_any_ack(10, n, to);
        n_cmp++; if ({to, bus.ACK0, bus.ERR0, bus.DOUT0} !== {1'b0, 1'b1, 1'b0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL to_after_read: got to=%b ack=%b err=%b d=%h want 0/1/0/deadbeef", to, bus.ACK0, bus.ERR0, bus.DOUT0); end
        bus.REQ0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_input_churn();
        bit to;
        int n;
        mem_lat = 3;
        bus.REQ0 = 1'b1; bus.WRITE0 = 1'b1; bus.ADDR0 = 30'h30; bus.DIN0 = 32'hCAFEF00D;
        wait_mem_req(10, to);
        for (int i = 0; i < 2; i++) begin
            bus.ADDR0 = 30'h31 + 30'(i);
            bus.DIN0  = 32'h0BAD0000 + 32'(i);
            @(negedge clk);
            n_cmp++; if ({bus.MEM_ADDR, bus.MEM_DIN} !== {30'h30, 32'hCAFEF00D}) begin n_bad++; $display("FAIL churn_latched: cycle %0d got %h/%h want 30/cafef00d", i, bus.MEM_ADDR, bus.MEM_DIN); end
        end
        wait_any_ack(10, n, to);
        n_cmp++; if ({to, bus.ACK0} !== 2'b01) begin n_bad++; $display("FAIL churn_ack0: got to=%b ack=%b want 0/1", to, bus.ACK0); end
        bus.REQ0 = 1'b0; bus.WRITE0 = 1'b0;
        @(negedge clk);
        n_cmp++; if ({mem[6'h30], mem[6'h31]} !== {32'hCAFEF00D, 32'h0}) begin n_bad++; $display("FAIL churn_mem: got %h/%h want cafef00d/0", mem[6'h30], mem[6'h31]); end
        mem_lat = 2;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_issue();
        bit to;
        int n;
        mem_en = 1'b0;
        bus.REQ1 = 1'b1; bus.WRITE1 = 1'b0; bus.ADDR1 = 30'h3;
        wait_mem_req(10, to);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.MEM_REQ, bus.MEM_ADDR, bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1} !== '0) begin n_bad++; $display("FAIL mid_rst_ctrl: got req=%b a=%h ack=%b%b err=%b%b want all 0", bus.MEM_REQ, bus.MEM_ADDR, bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1); end
        n_cmp++; if ({bus.DOUT0, bus.DOUT1} !== '0) begin n_bad++; $display("FAIL mid_rst_dout: got %h/%h want 0/0", bus.DOUT0, bus.DOUT1); end
        bus.REQ1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mem_en = 1'b1;
        bus.ADDR0 = 30'h1; bus.ADDR1 = 30'h2;
        bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
        wait_any_ack(10, n, to);
        n_cmp++; if ({to, bus.ACK0, bus.ACK1, bus.DOUT0} !== {1'b0, 1'b1, 1'b0, 32'h11111111}) begin n_bad++; $display("FAIL mid_rst_p0_first: got to=%b ack=%b%b d=%h want 0/10/11111111", to, bus.ACK0, bus.ACK1, bus.DOUT0); end
        bus.REQ0 = 1'b0;
        wait_any_ack(20, n, to);
        while (!to && !bus.ACK1) wait_any_ack(20, n, to);
        n_cmp++; if ({to, bus.ACK1, bus.DOUT1} !== {1'b0, 1'b1, 32'h22222222}) begin n_bad++; $display("FAIL mid_rst_p1_next: got to=%b ack=%b d=%h want 0/1/22222222", to, bus.ACK1, bus.DOUT1); end
        bus.REQ1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_protocol();
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL req_drop_before_ack: got %0d want 0", viol); end
    endtask

    initial begin
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        bus.WRITE0 = 1'b0; bus.WRITE1 = 1'b0;
        bus.ADDR0 = '0; bus.ADDR1 = '0;
        bus.DIN0 = '0; bus.DIN1 = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[6'h01] = 32'h11111111;
        mem[6'h02] = 32'h22222222;
        mem[6'h10] = 32'hDEADBEEF;
        mem_en = 1'b1;
        mem_lat = 2;
        man_ack = 1'b0;
        model_ack = 1'b0;
        model_dout = '0;
        lat_cnt = 0;

        test_reset();
        test_single_read();
        test_contention();
        test_write_readback();
        test_timeout();
        test_input_churn();
        test_reset_mid_issue();
        test_protocol();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
